// File: rtl/bcd_seg_scan_driver.sv
// bcd_seg_scan_driver
// Time-multiplexed driver for a NUM_DIGITS-wide common-cathode 7-segment
// display. A packed BCD word is captured into a shadow register and only
// committed to the displayed copy on the last cycle of a frame, so a scan
// never shows a mix of old and new digits. Each digit is held for DIV
// cycles. Leading zeros can be blanked, and codes above 9 show a dash and
// raise the invalid flag.
module bcd_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    lz_en,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start,
    output logic                    invalid
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = 4 * NUM_DIGITS;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    // BCD digit to {a,b,c,d,e,f,g}; anything outside 0..9 is a lone dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    logic [PW-1:0]         pre_r;
    logic [IW-1:0]         idx_r;
    logic [BW-1:0]         shadow_r;
    logic [BW-1:0]         disp_r;
    logic                  pending_r;

    logic                  pre_wrap_s;
    logic                  frame_end_s;
    logic                  commit_s;
    logic [3:0]            digit_s;
    logic [NUM_DIGITS-1:0] onehot_s;
    logic                  zero_run_s;
    logic                  suppress_s;
    logic                  invalid_s;
    logic [6:0]            seg_next_s;

    // Frame timing: digit-hold wrap, last cycle of frame, and commit decision.
    always_comb begin
        pre_wrap_s  = (pre_r == PRE_LAST);
        frame_end_s = pre_wrap_s && (idx_r == IDX_LAST);
        commit_s    = frame_end_s && (pending_r || load);
    end

    // Select the active digit, build its one-hot enable, and decide blanking
    // by walking from the most significant digit down while it stays zero.
    always_comb begin
        digit_s    = 4'd0;
        onehot_s   = '0;
        zero_run_s = 1'b1;
        suppress_s = 1'b0;
        invalid_s  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run_s  = zero_run_s & (disp_r[4*k +: 4] == 4'd0);
            invalid_s   = invalid_s | (disp_r[4*k +: 4] > 4'd9);
            onehot_s[k] = (idx_r == IW'(k));
            digit_s     = onehot_s[k] ? disp_r[4*k +: 4] : digit_s;
            suppress_s  = onehot_s[k] ? (lz_en & zero_run_s & (k != 0)) : suppress_s;
        end
        seg_next_s = suppress_s ? 7'd0 : seg_decode(digit_s);
    end

    // Scan counters and the shadow/display double buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r     <= '0;
            idx_r     <= '0;
            shadow_r  <= '0;
            disp_r    <= '0;
            pending_r <= 1'b0;
        end else begin
            pre_r <= pre_wrap_s ? '0 : pre_r + PW'(1);
            if (pre_wrap_s) begin
                idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
            end
            if (load) begin
                shadow_r  <= bcd_in;
                pending_r <= 1'b1;
            end
            // A load on the commit edge bypasses the shadow and lands directly.
            if (commit_s) begin
                disp_r    <= load ? bcd_in : shadow_r;
                pending_r <= 1'b0;
            end
        end
    end

    // Registered pin drivers, one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out     <= 7'd0;
            dig_sel     <= '0;
            frame_start <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            seg_out     <= seg_next_s;
            dig_sel     <= onehot_s;
            frame_start <= (idx_r == '0) && (pre_r == '0);
            invalid     <= invalid_s;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Testbench for bcd_seg_scan_driver: three instances (4x4, 1x1, 8x3) share
// the stimulus and are compared every cycle against a cycle-count based model.
module tb_bcd_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        lz_en;
    logic [31:0] bcd;

    logic [6:0] seg4, seg1, seg8;
    logic [3:0] sel4;
    logic [0:0] sel1;
    logic [7:0] sel8;
    logic       fs4, fs1, fs8;
    logic       inv4, inv1, inv8;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
        7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
    };

    int          n_of [3] = '{4, 1, 8};
    int          d_of [3] = '{4, 1, 3};
    int          m_t      [3];
    logic [31:0] m_disp   [3];
    logic [31:0] m_shadow [3];
    bit          m_pend   [3];
    logic [6:0]  e_seg    [3];
    logic [31:0] e_sel    [3];
    logic        e_fs     [3];
    logic        e_inv    [3];

    always #5 clk = ~clk;

    bcd_seg_scan_driver #(.NUM_DIGITS(4), .DIV(4)) u4 (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd[15:0]), .lz_en(lz_en),
        .seg_out(seg4), .dig_sel(sel4), .frame_start(fs4), .invalid(inv4));

    bcd_seg_scan_driver #(.NUM_DIGITS(1), .DIV(1)) u1 (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd[3:0]), .lz_en(lz_en),
        .seg_out(seg1), .dig_sel(sel1), .frame_start(fs1), .invalid(inv1));

    bcd_seg_scan_driver #(.NUM_DIGITS(8), .DIV(3)) u8 (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd), .lz_en(lz_en),
        .seg_out(seg8), .dig_sel(sel8), .frame_start(fs8), .invalid(inv8));

    function automatic logic [31:0] wmask(input int n);
        return (n >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * n)) - 32'd1);
    endfunction

    // Expected segments for digit idx of word w: blank if above the highest
    // nonzero digit with suppression on, otherwise the table entry.
    function automatic logic [6:0] ref_seg(input logic [31:0] w, input int n,
                                           input int idx, input bit lz);
        int msd = 0;
        for (int k = 0; k < n; k++)
            if (w[4*k +: 4] != 4'd0) msd = k;
        if (lz && idx > msd) return 7'd0;
        return SEG_TBL[w[4*idx +: 4]];
    endfunction

    function automatic logic ref_inv(input logic [31:0] w, input int n);
        logic r = 1'b0;
        for (int k = 0; k < n; k++)
            if (w[4*k +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, " seg4"}, {25'd0, seg4}, {25'd0, e_seg[0]});
        chk({ctx, " sel4"}, {28'd0, sel4}, e_sel[0]);
        chk({ctx, " fs4"},  {31'd0, fs4},  {31'd0, e_fs[0]});
        chk({ctx, " inv4"}, {31'd0, inv4}, {31'd0, e_inv[0]});
        chk({ctx, " seg1"}, {25'd0, seg1}, {25'd0, e_seg[1]});
        chk({ctx, " sel1"}, {31'd0, sel1}, e_sel[1]);
        chk({ctx, " fs1"},  {31'd0, fs1},  {31'd0, e_fs[1]});
        chk({ctx, " inv1"}, {31'd0, inv1}, {31'd0, e_inv[1]});
        chk({ctx, " seg8"}, {25'd0, seg8}, {25'd0, e_seg[2]});
        chk({ctx, " sel8"}, {24'd0, sel8}, e_sel[2]);
        chk({ctx, " fs8"},  {31'd0, fs8},  {31'd0, e_fs[2]});
        chk({ctx, " inv8"}, {31'd0, inv8}, {31'd0, e_inv[2]});
    endtask

    task automatic do_reset(input int cycles);
        rst  = 1'b1;
        load = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_t[i] = 0; m_disp[i] = 32'd0; m_shadow[i] = 32'd0; m_pend[i] = 1'b0;
            e_seg[i] = 7'd0; e_sel[i] = 32'd0; e_fs[i] = 1'b0; e_inv[i] = 1'b0;
        end
        check_all("reset");
        rst = 1'b0;
    endtask

    // One clock: outputs reflect the model before this edge; loads are
    // captured and the latest one commits on the frame's final cycle.
    task automatic step(input bit ld, input logic [31:0] b, input bit lz, input string ctx);
        int n, dv, idx, flen;
        load = ld; bcd = b; lz_en = lz;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n    = n_of[i];
            dv   = d_of[i];
            flen = n * dv;
            idx  = (m_t[i] / dv) % n;
            e_sel[i] = 32'd1 << idx;
            e_fs[i]  = ((m_t[i] % flen) == 0);
            e_seg[i] = ref_seg(m_disp[i], n, idx, lz);
            e_inv[i] = ref_inv(m_disp[i], n);
            if (ld) begin
                m_shadow[i] = b & wmask(n);
                m_pend[i]   = 1'b1;
            end
            if ((m_t[i] % flen) == flen - 1 && m_pend[i]) begin
                m_disp[i] = m_shadow[i];
                m_pend[i] = 1'b0;
            end
            m_t[i]++;
        end
        check_all(ctx);
        load = 1'b0;
    endtask

    // Idle until the 4-digit instance reaches frame cycle p (bounded).
    task automatic run_to_phase(input int p, input bit lz, input string ctx);
        int guard = 0;
        while ((m_t[0] % 16) != p && guard < 64) begin
            step(1'b0, 32'd0, lz, ctx);
            guard++;
        end
        if (guard >= 64) begin
            miscompares++;
            $error("FAIL %s phase wait timed out observed=%0d expected=%0d", ctx, m_t[0] % 16, p);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; lz_en = 1'b0; bcd = 32'd0;

        // Reset and plain scan of an all-zero display.
        do_reset(2);
        repeat (20) step(1'b0, $urandom, 1'b0, "scan");
        // Reset mid-frame.
        do_reset(1);
        repeat (6) step(1'b0, 32'd0, 1'b0, "rescan");

        // Load 1234 at frame cycle 5; shown from the next frame.
        run_to_phase(5, 1'b0, "pre1234");
        step(1'b1, 32'h0000_1234, 1'b0, "load1234");
        repeat (32) step(1'b0, 32'd0, 1'b0, "show1234");

        // Back-to-back loads, the second on the commit edge.
        run_to_phase(2, 1'b0, "pre5678");
        step(1'b1, 32'h0000_5678, 1'b0, "load5678");
        run_to_phase(15, 1'b0, "pre0009");
        step(1'b1, 32'h0000_0009, 1'b0, "load0009");
        repeat (16) step(1'b0, 32'd0, 1'b0, "show0009");
        repeat (16) step(1'b0, 32'd0, 1'b1, "lz0009");

        // Suppression of all-zero and interior-zero words.
        step(1'b1, 32'h0000_0000, 1'b1, "load0000");
        repeat (32) step(1'b0, 32'd0, 1'b1, "lz0000");
        step(1'b1, 32'h0000_0101, 1'b1, "load0101");
        repeat (32) step(1'b0, 32'd0, 1'b1, "lz0101");

        // Invalid code, then cleared.
        step(1'b1, 32'h0000_00A0, 1'b0, "load00A0");
        repeat (32) step(1'b0, 32'd0, 1'b0, "inv00A0");
        repeat (32) step(1'b0, 32'd0, 1'b1, "lzinv00A0");
        step(1'b1, 32'h0000_0000, 1'b0, "clear");
        repeat (32) step(1'b0, 32'd0, 1'b0, "cleared");

        // Randomized traffic with an occasional reset.
        repeat (300) step($urandom_range(0, 7) == 0, $urandom, 1'($urandom_range(0, 1)), "rand");
        do_reset(1);
        repeat (300) step($urandom_range(0, 5) == 0, $urandom, 1'($urandom_range(0, 1)), "rand2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
